// File: rtl/split_mixed_cond_pipe.sv
// split_mixed_cond_pipe
//   Purpose : multi-channel conditional-select register stage. Each channel adds
//             a constant OFFSET to its input and sends the sum down a DEPTH-stage
//             pipeline. Every cycle, each channel's registered output takes either
//             the last pipeline stage (condition high) or a 1-cycle override value
//             (condition low).
//   Latency : override path 1 edge. Pipelined path: a value sampled on edge N is
//             on out_val_e after edge N+DEPTH. The sampling edge is the first of
//             the DEPTH+1 edges involved, so DEPTH=1 gives the 2-edge behaviour.
//   Flow    : no backpressure. The pipeline advances every cycle. A shared valid
//             bit travels with the data. Invalid data never overwrites the output;
//             the output holds its previous value instead.
//
// Ports
//   clk_e          clock, rising edge
//   rst_e          asynchronous active-high reset (release is synchronous to clk_e)
//   in_valid_e     qualifies in_val_e for every channel this cycle
//   in_val_e       channel c at bits [c*WIDTH +: WIDTH]
//   in_override_e  per-channel override value, same packing as in_val_e
//   condition_e    per-channel select: 1 = pipelined sum, 0 = override
//   clr_ovf_e      synchronous clear of all sticky overflow flags
//   out_val_e      registered selected value per channel
//   status_e       1 = out_val_e[c] was loaded from the sum pipeline on the last edge
//   ovf_e          sticky per-channel overflow flag (carry out of the offset add)
//   hit_count_e    saturating count of edges that left any status_e bit set

module split_mixed_cond_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 1,
  parameter int OFFSET   = 5,
  parameter int SATURATE = 0,
  parameter int COUNT_W  = 16
) (
  input  logic                         clk_e,
  input  logic                         rst_e,
  input  logic                         in_valid_e,
  input  logic [CHANNELS*WIDTH-1:0]    in_val_e,
  input  logic [CHANNELS*WIDTH-1:0]    in_override_e,
  input  logic [CHANNELS-1:0]          condition_e,
  input  logic                         clr_ovf_e,
  output logic [CHANNELS*WIDTH-1:0]    out_val_e,
  output logic [CHANNELS-1:0]          status_e,
  output logic [CHANNELS-1:0]          ovf_e,
  output logic [COUNT_W-1:0]           hit_count_e
);

  // OFFSET is truncated to the channel width before the add.
  localparam logic [WIDTH-1:0] OFF_W = WIDTH'(OFFSET);

  // ---------------------------------------------------------------------------
  // Stage-0 sum and carry detection
  // ---------------------------------------------------------------------------
  logic [CHANNELS*WIDTH-1:0] stage0_d;
  logic [CHANNELS-1:0]       carry_d;

  always_comb begin
    logic [WIDTH:0] sum_full;
    stage0_d = '0;
    carry_d  = '0;
    sum_full = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      // The add is done one bit wider so the carry-out is visible.
      sum_full = {1'b0, in_val_e[c*WIDTH +: WIDTH]} + {1'b0, OFF_W};
      carry_d[c] = sum_full[WIDTH];
      if ((SATURATE != 0) && sum_full[WIDTH]) begin
        stage0_d[c*WIDTH +: WIDTH] = '1;
      end else begin
        stage0_d[c*WIDTH +: WIDTH] = sum_full[WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sum pipeline: DEPTH stages. All channels share one valid bit per stage.
  // ---------------------------------------------------------------------------
  logic [CHANNELS*WIDTH-1:0] pipe_q [DEPTH];
  logic [DEPTH-1:0]          pipe_vld_q;

  always_ff @(posedge clk_e or posedge rst_e) begin
    if (rst_e) begin
      for (int k = 0; k < DEPTH; k++) begin
        pipe_q[k] <= '0;
      end
      pipe_vld_q <= '0;
    end else begin
      pipe_q[0]     <= stage0_d;
      pipe_vld_q[0] <= in_valid_e;
      for (int k = 1; k < DEPTH; k++) begin
        pipe_q[k]     <= pipe_q[k-1];
        pipe_vld_q[k] <= pipe_vld_q[k-1];
      end
    end
  end

  logic [CHANNELS*WIDTH-1:0] last_dat;
  logic                      last_vld;

  assign last_dat = pipe_q[DEPTH-1];
  assign last_vld = pipe_vld_q[DEPTH-1];

  // ---------------------------------------------------------------------------
  // Output select, overflow flags and hit counter (next state)
  // ---------------------------------------------------------------------------
  logic [CHANNELS*WIDTH-1:0] out_q,    out_d;
  logic [CHANNELS-1:0]       status_q, status_d;
  logic [CHANNELS-1:0]       ovf_q,    ovf_d;
  logic [COUNT_W-1:0]        cnt_q,    cnt_d;

  always_comb begin
    out_d    = out_q;
    status_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!condition_e[c]) begin
        out_d[c*WIDTH +: WIDTH] = in_override_e[c*WIDTH +: WIDTH];
      end else if (last_vld) begin
        out_d[c*WIDTH +: WIDTH] = last_dat[c*WIDTH +: WIDTH];
        status_d[c]             = 1'b1;
      end
      // condition high with an invalid last stage: the output keeps its old value.
    end
  end

  // Clear first, then OR in new overflows, so a set on the same edge wins.
  always_comb begin
    ovf_d = clr_ovf_e ? '0 : ovf_q;
    if (in_valid_e) begin
      ovf_d = ovf_d | carry_d;
    end
  end

  // The counter looks at next-state status so it counts the edge that produces
  // the hit. It sticks at all-ones and never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if ((|status_d) && (cnt_q != '1)) begin
      cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk_e or posedge rst_e) begin
    if (rst_e) begin
      out_q    <= '0;
      status_q <= '0;
      ovf_q    <= '0;
      cnt_q    <= '0;
    end else begin
      out_q    <= out_d;
      status_q <= status_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_val_e   = out_q;
  assign status_e    = status_q;
  assign ovf_e       = ovf_q;
  assign hit_count_e = cnt_q;

endmodule

// File: tb/tb_split_mixed_cond_pipe.sv
// tb_split_mixed_cond_pipe
//   Purpose : directed, table-driven check of split_mixed_cond_pipe.
//   Instances: u0 default, u1 SATURATE=1, u2 DEPTH=3, u3 DEPTH=2 with COUNT_W=4.
//   All four instances share one stimulus, and each is checked where relevant.

module tb_split_mixed_cond_pipe;

  logic        clk_e = 1'b0;
  logic        rst_e;
  logic        in_valid_e;
  logic [15:0] in_val_e;
  logic [15:0] in_override_e;
  logic [1:0]  condition_e;
  logic        clr_ovf_e;

  logic [15:0] out0, out1, out2, out3;
  logic [1:0]  st0, st1, st2, st3;
  logic [1:0]  ovf0, ovf1, ovf2, ovf3;
  logic [15:0] cnt0, cnt1, cnt2;
  logic [3:0]  cnt3;

  int errors = 0;
  int checks = 0;

  always #5 clk_e = ~clk_e;

  split_mixed_cond_pipe u0 (
    .clk_e(clk_e), .rst_e(rst_e), .in_valid_e(in_valid_e), .in_val_e(in_val_e),
    .in_override_e(in_override_e), .condition_e(condition_e), .clr_ovf_e(clr_ovf_e),
    .out_val_e(out0), .status_e(st0), .ovf_e(ovf0), .hit_count_e(cnt0));

  split_mixed_cond_pipe #(.SATURATE(1)) u1 (
    .clk_e(clk_e), .rst_e(rst_e), .in_valid_e(in_valid_e), .in_val_e(in_val_e),
    .in_override_e(in_override_e), .condition_e(condition_e), .clr_ovf_e(clr_ovf_e),
    .out_val_e(out1), .status_e(st1), .ovf_e(ovf1), .hit_count_e(cnt1));

  split_mixed_cond_pipe #(.DEPTH(3)) u2 (
    .clk_e(clk_e), .rst_e(rst_e), .in_valid_e(in_valid_e), .in_val_e(in_val_e),
    .in_override_e(in_override_e), .condition_e(condition_e), .clr_ovf_e(clr_ovf_e),
    .out_val_e(out2), .status_e(st2), .ovf_e(ovf2), .hit_count_e(cnt2));

  split_mixed_cond_pipe #(.DEPTH(2), .COUNT_W(4)) u3 (
    .clk_e(clk_e), .rst_e(rst_e), .in_valid_e(in_valid_e), .in_val_e(in_val_e),
    .in_override_e(in_override_e), .condition_e(condition_e), .clr_ovf_e(clr_ovf_e),
    .out_val_e(out3), .status_e(st3), .ovf_e(ovf3), .hit_count_e(cnt3));

  typedef struct {
    logic        vld;
    logic [15:0] in;
    logic [15:0] ovr;
    logic [1:0]  cond;
    logic        clr;
    logic [15:0] exp_out;
    logic [1:0]  exp_st;
    logic [1:0]  exp_ovf;
    logic [15:0] exp_cnt;
    logic [15:0] exp_sat_out;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_e);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [15:0] in, input logic [15:0] ovr,
                       input logic [1:0] cond, input logic clr);
    in_valid_e    = vld;
    in_val_e      = in;
    in_override_e = ovr;
    condition_e   = cond;
    clr_ovf_e     = clr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_c;

    // Expected values are for u0 (DEPTH=1, OFFSET=5, wrap). exp_sat_out is u1.
    //             vld  in        ovr       cond   clr   out       st     ovf    cnt  sat_out
    vecs[0] = '{1'b1, 16'h0010, 16'hA500, 2'b01, 1'b0, 16'hA500, 2'b00, 2'b00, 16'd0, 16'hA500};
    vecs[1] = '{1'b0, 16'h0000, 16'hA533, 2'b01, 1'b0, 16'hA515, 2'b01, 2'b00, 16'd1, 16'hA515};
    vecs[2] = '{1'b0, 16'h0000, 16'h5A33, 2'b01, 1'b0, 16'h5A15, 2'b00, 2'b00, 16'd1, 16'h5A15};
    vecs[3] = '{1'b1, 16'hFFFE, 16'hC300, 2'b01, 1'b0, 16'hC315, 2'b00, 2'b11, 16'd1, 16'hC315};
    vecs[4] = '{1'b0, 16'h0000, 16'h1100, 2'b11, 1'b0, 16'h0403, 2'b11, 2'b11, 16'd2, 16'hFFFF};
    vecs[5] = '{1'b0, 16'h0000, 16'h1100, 2'b11, 1'b1, 16'h0403, 2'b00, 2'b00, 16'd2, 16'hFFFF};
    vecs[6] = '{1'b1, 16'h00FE, 16'h2244, 2'b00, 1'b1, 16'h2244, 2'b00, 2'b01, 16'd2, 16'h2244};
    vecs[7] = '{1'b1, 16'h0110, 16'h0077, 2'b10, 1'b0, 16'h0577, 2'b10, 2'b01, 16'd3, 16'h0577};
    vecs[8] = '{1'b0, 16'h0000, 16'h0000, 2'b11, 1'b0, 16'h0615, 2'b11, 2'b01, 16'd4, 16'h0615};

    // Reset state, observed before any clock edge.
    rst_e = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
    #3;
    chk("reset_out", out0, 16'h0);
    chk("reset_status", st0, 2'b00);
    chk("reset_ovf", ovf0, 2'b00);
    chk("reset_cnt", cnt0, 16'd0);
    #10;
    rst_e = 1'b0;

    // Table-driven main function: select, override, wrap/saturate, ovf set/clear.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].vld, vecs[i].in, vecs[i].ovr, vecs[i].cond, vecs[i].clr);
      tick();
      chk($sformatf("v%0d_out", i), out0, vecs[i].exp_out);
      chk($sformatf("v%0d_status", i), st0, vecs[i].exp_st);
      chk($sformatf("v%0d_ovf", i), ovf0, vecs[i].exp_ovf);
      chk($sformatf("v%0d_cnt", i), cnt0, vecs[i].exp_cnt);
      chk($sformatf("v%0d_sat_out", i), out1, vecs[i].exp_sat_out);
      chk($sformatf("v%0d_sat_ovf", i), ovf1, vecs[i].exp_ovf);
    end

    // Reset mid-flight: fill u3's two stages with valid data, then reset between edges.
    drive(1'b1, 16'h0102, 16'h0000, 2'b11, 1'b0);
    tick();
    tick();
    rst_e = 1'b1;
    #1;
    chk("midrst_u0_out", out0, 16'h0);
    chk("midrst_u0_cnt", cnt0, 16'd0);
    chk("midrst_u1_out", out1, 16'h0);
    chk("midrst_u2_out", out2, 16'h0);
    chk("midrst_u3_out", out3, 16'h0);
    chk("midrst_u3_status", st3, 2'b00);
    chk("midrst_u3_ovf", ovf3, 2'b00);
    chk("midrst_u3_cnt", cnt3, 4'd0);
    #2;
    rst_e = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 2'b11, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("postrst%0d_status", k), st3, 2'b00);
      chk($sformatf("postrst%0d_out", k), out3, 16'h0);
      chk($sformatf("postrst%0d_cnt", k), cnt3, 4'd0);
    end

    // Counter saturation on u3 (DEPTH=2): the first hit lands on the third edge.
    drive(1'b1, 16'h0000, 16'h0, 2'b11, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      tick();
      exp_c = (k <= 2) ? 0 : ((k - 2 > 15) ? 15 : k - 2);
      chk($sformatf("sat_cnt_e%0d", k), cnt3, 32'(exp_c));
    end

    // Invalid hold on u2 (DEPTH=3).
    rst_e = 1'b1;
    #2;
    rst_e = 1'b0;
    drive(1'b0, 16'h0, 16'h0020, 2'b00, 1'b0);
    tick();
    chk("hold_load", out2[7:0], 8'h20);
    drive(1'b0, 16'h0, 16'h0, 2'b01, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("hold%0d_out", k), out2[7:0], 8'h20);
      chk($sformatf("hold%0d_status", k), st2[0], 1'b0);
      chk($sformatf("hold%0d_cnt", k), cnt2, 16'd0);
    end
    // 8'h01 is sampled on edge N and shows as 8'h06 after edge N+3.
    drive(1'b1, 16'h0001, 16'h0, 2'b01, 1'b0);
    tick();
    chk("lat_e0_out", out2[7:0], 8'h20);
    drive(1'b0, 16'h0, 16'h0, 2'b01, 1'b0);
    tick();
    chk("lat_e1_out", out2[7:0], 8'h20);
    tick();
    chk("lat_e2_out", out2[7:0], 8'h20);
    chk("lat_e2_status", st2[0], 1'b0);
    tick();
    chk("lat_e3_out", out2[7:0], 8'h06);
    chk("lat_e3_status", st2[0], 1'b1);
    chk("lat_e3_cnt", cnt2, 16'd1);
    tick();
    chk("lat_e4_hold", out2[7:0], 8'h06);
    chk("lat_e4_status", st2[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
